// File: rtl/mz_gvram_pkg.sv
// rtl/mz_gvram_pkg.sv - MZ-80B GVRAM raster geometry shared by the video blocks
package mz_gvram_pkg;

    localparam int H_ACTIVE = 320;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 32;
    localparam int H_BP     = 56;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 200;
    localparam int V_FP     = 22;
    localparam int V_SYNC   = 4;
    localparam int V_BP     = 36;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int BYTES_PER_LINE = H_ACTIVE / 8;
    localparam int GVRAM_BYTES    = BYTES_PER_LINE * V_ACTIVE;
    localparam int ADDR_W         = 13;

endpackage

// File: rtl/mz_edge_det.sv
// rtl/mz_edge_det.sv - one-flop rising-edge detector turning the divider square wave into dot_en
module mz_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) din_q <= 1'b0;
        else        din_q <= din;
    end

    assign pulse = din & ~din_q;

endmodule

// File: rtl/mz_video_timing.sv
// rtl/mz_video_timing.sv - raster counters, sync/blank decode and GVRAM byte fetch addressing
// Optional MZ_VTIMING_VBLK_PULSE_EN enables the vblk_start strobe at the start of vertical blank.
module mz_video_timing
    import mz_gvram_pkg::*;
#(
    parameter int H_ACTIVE = mz_gvram_pkg::H_ACTIVE,
    parameter int H_FP     = mz_gvram_pkg::H_FP,
    parameter int H_SYNC   = mz_gvram_pkg::H_SYNC,
    parameter int H_BP     = mz_gvram_pkg::H_BP,
    parameter int V_ACTIVE = mz_gvram_pkg::V_ACTIVE,
    parameter int V_FP     = mz_gvram_pkg::V_FP,
    parameter int V_SYNC   = mz_gvram_pkg::V_SYNC,
    parameter int V_BP     = mz_gvram_pkg::V_BP,
    parameter int ADDR_W   = mz_gvram_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              div_in,
    output logic              hsync_n,
    output logic              vsync_n,
    output logic              blank,
    output logic              byte_ld,
    output logic [ADDR_W-1:0] gvram_addr,
    output logic              vblk_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE % 8 != 0) begin : g_h_active_check
        $error("H_ACTIVE must be a multiple of 8");
    end

    logic              dot_en;
    logic              dot_d;
    logic              run;
    logic [HW-1:0]     hcnt;
    logic [VW-1:0]     vcnt;
    logic [ADDR_W-1:0] addr;
    logic              h_wrap;
    logic              v_wrap;
    logic              in_act;
    logic              fetch;

    mz_edge_det u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (div_in),
        .pulse (dot_en)
    );

    assign h_wrap = (hcnt == H_LAST);
    assign v_wrap = (vcnt == V_LAST);
    assign in_act = (hcnt < H_ACT) && (vcnt < V_ACT);
    assign fetch  = in_act && (hcnt[2:0] == 3'd0);

    // The first dot after reset lands on (0,0) rather than advancing past it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dot_d <= 1'b0;
            run   <= 1'b0;
            hcnt  <= '0;
            vcnt  <= '0;
            addr  <= '0;
        end else begin
            dot_d <= dot_en;
            if (dot_en) begin
                run <= 1'b1;
                if (run) begin
                    if (h_wrap) begin
                        hcnt <= '0;
                        vcnt <= v_wrap ? '0 : vcnt + 1'b1;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
            end
            if (dot_en && run && h_wrap && v_wrap) addr <= '0;
            else if (dot_d && fetch)                addr <= addr + 1'b1;
        end
    end

    // Outputs decode the position one clk after dot_en moved the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_n    <= 1'b1;
            vsync_n    <= 1'b1;
            blank      <= 1'b1;
            byte_ld    <= 1'b0;
            gvram_addr <= '0;
        end else begin
            byte_ld <= dot_d && fetch;
            if (dot_d) begin
                blank   <= !in_act;
                hsync_n <= !((hcnt >= HS_BEG) && (hcnt < HS_END));
                vsync_n <= !((vcnt >= VS_BEG) && (vcnt < VS_END));
                if (fetch) gvram_addr <= addr;
            end
        end
    end

`ifdef MZ_VTIMING_VBLK_PULSE_EN
    logic vblk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vblk_q <= 1'b0;
        else        vblk_q <= dot_d && (hcnt == '0) && (vcnt == V_ACT);
    end

    assign vblk_start = vblk_q;
`else
    assign vblk_start = 1'b0;
`endif

endmodule

// File: tb/tb_mz_video_timing.sv
// tb/tb_mz_video_timing.sv - directed bench: full-size timing for the first lines, reduced geometry for whole frames
module tb_mz_video_timing;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        div_in;

    logic        d_hs, d_vs, d_blank, d_ld, d_vblk;
    logic [12:0] d_addr;
    logic        s_hs, s_vs, s_blank, s_ld, s_vblk;
    logic [12:0] s_addr;

    logic        cd_hs, cd_vs, cd_blank, cd_ld, cd_vblk;
    logic [12:0] cd_addr;
    logic        cs_hs, cs_vs, cs_blank, cs_ld, cs_vblk;
    logic [12:0] cs_addr;
    int          cd_cyc;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int d_ld_cnt = 0;
    int s_ld_cnt = 0;
    int d_vblk_cnt = 0;
    int s_vblk_cnt = 0;

`ifdef MZ_VTIMING_VBLK_PULSE_EN
    localparam bit VBLK_ON = 1'b1;
`else
    localparam bit VBLK_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    mz_video_timing u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_in     (div_in),
        .hsync_n    (d_hs),
        .vsync_n    (d_vs),
        .blank      (d_blank),
        .byte_ld    (d_ld),
        .gvram_addr (d_addr),
        .vblk_start (d_vblk)
    );

    // Small geometry: 24 dots x 7 lines, 16x3 active, hsync dots 18..20, vsync lines 4..5.
    mz_video_timing #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (3),  .V_FP (1), .V_SYNC (2), .V_BP (1),
        .ADDR_W   (13)
    ) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_in     (div_in),
        .hsync_n    (s_hs),
        .vsync_n    (s_vs),
        .blank      (s_blank),
        .byte_ld    (s_ld),
        .gvram_addr (s_addr),
        .vblk_start (s_vblk)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (d_ld === 1'b1)   d_ld_cnt++;
        if (s_ld === 1'b1)   s_ld_cnt++;
        if (d_vblk === 1'b1) d_vblk_cnt++;
        if (s_vblk === 1'b1) s_vblk_cnt++;
    end

    // One divider period starting at a negedge; outputs captured two negedges after the rise.
    task automatic dot(input int half);
        div_in = 1'b1;
        for (int i = 1; i <= 2 * half; i++) begin
            @(negedge clk);
            if (i == 2) begin
                cd_hs = d_hs; cd_vs = d_vs; cd_blank = d_blank; cd_ld = d_ld;
                cd_addr = d_addr; cd_vblk = d_vblk; cd_cyc = cyc;
                cs_hs = s_hs; cs_vs = s_vs; cs_blank = s_blank; cs_ld = s_ld;
                cs_addr = s_addr; cs_vblk = s_vblk;
            end
            if (i == half) div_in = 1'b0;
        end
    endtask

    task automatic test_reset();
        int bad = 0;
        int ld0;
        rst_n  = 1'b0;
        div_in = 1'b0;
        ld0 = d_ld_cnt + s_ld_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            div_in = ~div_in;
            if ({d_hs, d_vs, d_blank, d_ld, d_vblk} !== 5'b11100 || d_addr !== 13'd0) bad++;
            if ({s_hs, s_vs, s_blank, s_ld, s_vblk} !== 5'b11100 || s_addr !== 13'd0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL reset_hold: %0d samples off reset values, required 0", bad);
        end
        tests++;
        if (d_ld_cnt + s_ld_cnt - ld0 !== 0) begin
            fails++;
            $display("FAIL reset_no_byte_ld: %0d strobes, required 0", d_ld_cnt + s_ld_cnt - ld0);
        end
        div_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (d_blank !== 1'b1 || d_ld !== 1'b0 || d_hs !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_idle: blank=%b byte_ld=%b hsync_n=%b, required 1 0 1",
                     d_blank, d_ld, d_hs);
        end
    endtask

    // Two full-size lines at divide-by-12.
    task automatic test_first_lines();
        int bad_blank = 0, bad_hs = 0, bad_vs = 0, bad_ld = 0, bad_addr = 0, bad_gap = 0;
        int exp_addr = 0;
        int prev_cyc = 0;
        int ld0, vb0;
        ld0 = d_ld_cnt;
        vb0 = d_vblk_cnt;
        for (int v = 0; v < 2; v++) begin
            for (int h = 0; h < 424; h++) begin
                logic e_blank, e_hs, e_ld;
                dot(6);
                e_blank = !(h < 320);
                e_hs    = !(h >= 336 && h < 368);
                e_ld    = (h < 320) && (h % 8 == 0);
                if (cd_blank !== e_blank) bad_blank++;
                if (cd_hs !== e_hs)       bad_hs++;
                if (cd_vs !== 1'b1)       bad_vs++;
                if (cd_ld !== e_ld)       bad_ld++;
                if (e_ld) begin
                    if (cd_addr !== 13'(exp_addr)) bad_addr++;
                    if (h != 0 && cd_cyc - prev_cyc != 96) bad_gap++;
                    prev_cyc = cd_cyc;
                    exp_addr++;
                end
                if (v == 0 && h == 0) begin
                    tests++;
                    if (cd_ld !== 1'b1 || cd_addr !== 13'd0) begin
                        fails++;
                        $display("FAIL first_byte: byte_ld=%b addr=%0d, required 1 0", cd_ld, cd_addr);
                    end
                end
            end
        end
        tests++; if (bad_blank !== 0) begin fails++; $display("FAIL line_blank: %0d dots wrong, required 0", bad_blank); end
        tests++; if (bad_hs !== 0)    begin fails++; $display("FAIL line_hsync: %0d dots wrong, required 0", bad_hs); end
        tests++; if (bad_vs !== 0)    begin fails++; $display("FAIL line_vsync: %0d dots wrong, required 0", bad_vs); end
        tests++; if (bad_ld !== 0)    begin fails++; $display("FAIL line_byte_ld: %0d dots wrong, required 0", bad_ld); end
        tests++; if (bad_addr !== 0)  begin fails++; $display("FAIL line_addr: %0d addresses wrong, required 0", bad_addr); end
        tests++; if (bad_gap !== 0)   begin fails++; $display("FAIL byte_spacing: %0d gaps not 96 clk, required 0", bad_gap); end
        tests++;
        if (d_ld_cnt - ld0 !== 80) begin
            fails++;
            $display("FAIL line_strobe_count: %0d strobes, required 80", d_ld_cnt - ld0);
        end
        tests++;
        if (d_vblk_cnt - vb0 !== 0) begin
            fails++;
            $display("FAIL vblk_in_active: %0d pulses, required 0", d_vblk_cnt - vb0);
        end
    endtask

    // Line 2: stop after the dot-96 fetch, idle 500 clk, then resume to dot 104.
    task automatic test_stall();
        int bad = 0;
        int ld0;
        for (int h = 0; h <= 96; h++) dot(6);
        tests++;
        if (cd_ld !== 1'b1 || cd_addr !== 13'd92) begin
            fails++;
            $display("FAIL stall_pre: byte_ld=%b addr=%0d, required 1 92", cd_ld, cd_addr);
        end
        ld0 = d_ld_cnt;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (d_blank !== 1'b0 || d_hs !== 1'b1 || d_vs !== 1'b1 ||
                d_ld !== 1'b0 || d_addr !== 13'd92) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL stall_frozen: %0d clk with changed outputs, required 0", bad);
        end
        for (int h = 97; h <= 104; h++) dot(6);
        tests++;
        if (cd_ld !== 1'b1 || cd_addr !== 13'd93) begin
            fails++;
            $display("FAIL stall_resume: byte_ld=%b addr=%0d, required 1 93", cd_ld, cd_addr);
        end
        tests++;
        if (d_ld_cnt - ld0 !== 1) begin
            fails++;
            $display("FAIL stall_strobes: %0d strobes, required 1", d_ld_cnt - ld0);
        end
    endtask

    // Two complete frames of the reduced geometry at divide-by-2.
    task automatic test_small_frames();
        int bad_blank = 0, bad_hs = 0, bad_vs = 0, bad_ld = 0, bad_addr = 0, bad_vblk = 0;
        int ld0, vb0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            ld0 = s_ld_cnt;
            vb0 = s_vblk_cnt;
            for (int v = 0; v < 7; v++) begin
                for (int h = 0; h < 24; h++) begin
                    logic e_blank, e_hs, e_vs, e_ld, e_vblk;
                    dot(1);
                    e_blank = !(h < 16 && v < 3);
                    e_hs    = !(h >= 18 && h < 21);
                    e_vs    = !(v >= 4 && v < 6);
                    e_ld    = (h < 16) && (h % 8 == 0) && (v < 3);
                    e_vblk  = VBLK_ON && (h == 0) && (v == 3);
                    if (cs_blank !== e_blank) bad_blank++;
                    if (cs_hs !== e_hs)       bad_hs++;
                    if (cs_vs !== e_vs)       bad_vs++;
                    if (cs_ld !== e_ld)       bad_ld++;
                    if (cs_vblk !== e_vblk)   bad_vblk++;
                    if (e_ld && cs_addr !== 13'(v * 2 + h / 8)) bad_addr++;
                    if (f == 1 && v == 0 && h == 0) begin
                        tests++;
                        if (cs_ld !== 1'b1 || cs_addr !== 13'd0) begin
                            fails++;
                            $display("FAIL frame_wrap: byte_ld=%b addr=%0d, required 1 0", cs_ld, cs_addr);
                        end
                    end
                end
            end
            tests++;
            if (s_ld_cnt - ld0 !== 6) begin
                fails++;
                $display("FAIL frame_strobes: frame %0d has %0d, required 6", f, s_ld_cnt - ld0);
            end
            tests++;
            if (s_vblk_cnt - vb0 !== (VBLK_ON ? 1 : 0)) begin
                fails++;
                $display("FAIL vblk_count: frame %0d has %0d, required %0d", f, s_vblk_cnt - vb0, VBLK_ON ? 1 : 0);
            end
        end
        tests++; if (bad_blank !== 0) begin fails++; $display("FAIL frame_blank: %0d dots wrong, required 0", bad_blank); end
        tests++; if (bad_hs !== 0)    begin fails++; $display("FAIL frame_hsync: %0d dots wrong, required 0", bad_hs); end
        tests++; if (bad_vs !== 0)    begin fails++; $display("FAIL frame_vsync: %0d dots wrong, required 0", bad_vs); end
        tests++; if (bad_ld !== 0)    begin fails++; $display("FAIL frame_byte_ld: %0d dots wrong, required 0", bad_ld); end
        tests++; if (bad_addr !== 0)  begin fails++; $display("FAIL frame_addr: %0d addresses wrong, required 0", bad_addr); end
        tests++; if (bad_vblk !== 0)  begin fails++; $display("FAIL frame_vblk: %0d dots wrong, required 0", bad_vblk); end
    endtask

    // Reset mid-frame between clock edges, then restart from (0,0).
    task automatic test_async_reset();
        for (int i = 0; i < 2 * 24 + 9; i++) dot(1);
        tests++;
        if (cs_ld !== 1'b1 || cs_addr !== 13'd5 || cs_blank !== 1'b0) begin
            fails++;
            $display("FAIL areset_pre: byte_ld=%b addr=%0d blank=%b, required 1 5 0", cs_ld, cs_addr, cs_blank);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({s_hs, s_vs, s_blank, s_ld, s_vblk} !== 5'b11100 || s_addr !== 13'd0) begin
            fails++;
            $display("FAIL areset_immediate: hs=%b vs=%b blank=%b ld=%b vblk=%b addr=%0d, required 1 1 1 0 0 0",
                     s_hs, s_vs, s_blank, s_ld, s_vblk, s_addr);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dot(1);
        tests++;
        if (cs_ld !== 1'b1 || cs_addr !== 13'd0 || cs_blank !== 1'b0) begin
            fails++;
            $display("FAIL areset_restart: byte_ld=%b addr=%0d blank=%b, required 1 0 0", cs_ld, cs_addr, cs_blank);
        end
        for (int h = 1; h <= 8; h++) dot(1);
        tests++;
        if (cs_ld !== 1'b1 || cs_addr !== 13'd1) begin
            fails++;
            $display("FAIL areset_second_byte: byte_ld=%b addr=%0d, required 1 1", cs_ld, cs_addr);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        div_in = 1'b0;
        test_reset();
        test_first_lines();
        test_stall();
        test_small_frames();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
